// File: rtl/serializer.sv
// Generic FIFO: power-of-two depth, wrapping pointers, exact occupancy count.
// Latency: a pushed word is visible at rdat on the cycle after the push edge.
// Backpressure: full blocks pushes (push while full is dropped); pop while empty is ignored.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdat,
    input  logic             pop,
    output logic [W-1:0]     rdat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign rdat    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdat;
    end
endmodule

// Parallel-to-serial transmitter: WIDTH LSB-first data slots plus one gap slot per frame.
// Latency: a word pushed into an empty FIFO reaches dout 1..WIDTH+1 cycles later.
// Backpressure: tx_ready = !full; the FIFO drains one word per WIDTH+1 cycles.
module serializer #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          dout,
    output logic                          frame_start,
    output logic                          frame_active,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              words_sent
);
    localparam int SLOT_W = $clog2(WIDTH + 1);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic [SLOT_W-1:0] slot;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  head;
    logic              gap;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign gap  = (slot == SLOT_W'(WIDTH));
    assign push = tx_valid && !fifo_full;
    // Pop decision uses pre-edge emptiness, so a word pushed on the gap edge waits a frame.
    assign pop  = gap && !fifo_empty;

    fifo #(
        .W     (WIDTH),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdat  (tx_data),
        .pop   (pop),
        .rdat  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot         <= '0;
            shreg        <= '0;
            frame_active <= 1'b0;
            underflow    <= 1'b0;
            words_sent   <= '0;
        end else if (gap) begin
            slot <= '0;
            if (!fifo_empty) begin
                shreg        <= head;
                frame_active <= 1'b1;
                underflow    <= 1'b0;
                words_sent   <= words_sent + CNT_W'(1);
            end else begin
                shreg        <= '0;
                frame_active <= 1'b0;
                underflow    <= 1'b1;
            end
        end else begin
            slot      <= slot + SLOT_W'(1);
            shreg     <= shreg >> 1;
            underflow <= 1'b0;
        end
    end

    assign tx_ready    = !fifo_full;
    assign frame_start = (slot == '0);
    assign dout        = frame_active && !gap && shreg[0];
endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: frame-level reference model plus directed scenarios with literal pins.
module tb_serializer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              dout;
    logic              frame_start;
    logic              frame_active;
    logic              underflow;
    logic [2:0]        fifo_level;
    logic [CNT_W-1:0]  words_sent;

    serializer #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .dout         (dout),
        .frame_start  (frame_start),
        .frame_active (frame_active),
        .underflow    (underflow),
        .fifo_level   (fifo_level),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue, the current frame's word and the slot number.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] rx[$];
    logic [WIDTH-1:0] m_cur;
    logic [WIDTH-1:0] cap;
    int               m_slot;
    int               m_ws;
    bit               m_act;
    bit               m_uf;
    bit               m_cp;
    int               max_lvl;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                rx.delete();
                m_slot = 0;
                m_act  = 0;
                m_cur  = '0;
                m_uf   = 0;
                m_ws   = 0;
            end else begin
                m_cp = tx_valid && (q.size() < DEPTH);
                m_uf = 0;
                if (m_slot == WIDTH) begin
                    m_slot = 0;
                    if (q.size() > 0) begin
                        m_cur = q.pop_front();
                        m_act = 1;
                        m_ws++;
                    end else begin
                        m_cur = '0;
                        m_act = 0;
                        m_uf  = 1;
                    end
                end else begin
                    m_slot++;
                end
                if (m_cp) q.push_back(tx_data);
            end
        end
    end

    // Per-cycle compare, plus a deserializer-style capture of dout.
    initial begin
        logic exp_dout;
        forever begin
            @(negedge clk);
            exp_dout = (m_act && m_slot < WIDTH) ? m_cur[m_slot] : 1'b0;
            check("dout", dout, exp_dout);
            check("tx_ready", tx_ready, q.size() < DEPTH);
            check("frame_start", frame_start, m_slot == 0);
            check("frame_active", frame_active, m_act);
            check("underflow", underflow, m_uf);
            check("fifo_level", fifo_level, q.size());
            check("words_sent", words_sent, m_ws[15:0]);
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (m_slot < WIDTH) cap[m_slot] = dout;
            if (m_act && m_slot == WIDTH) begin
                check("loopback", cap, m_cur);
                rx.push_back(cap);
            end
        end
    end

    task automatic wait_slot(input int k);
        int n = 0;
        @(negedge clk);
        while (m_slot != k && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_slot_timeout", n < 200, 1);
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        int n = 0;
        logic r;
        tx_data  = w;
        tx_valid = 1'b1;
        do begin
            r = tx_ready;
            @(negedge clk);
            n++;
        end while (!r && n < 500);
        tx_valid = 1'b0;
        check("push_timeout", r, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        max_lvl = 0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 5000, 1);
        wait_slot(WIDTH);
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] words6 [6];
    logic [WIDTH-1:0] sent[$];
    int bad;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        max_lvl = 0;
        repeat (2) @(negedge clk);
        // Reset values while rst_n is held low.
        check("rst_tx_ready", tx_ready, 1);
        check("rst_dout", dout, 0);
        check("rst_frame_start", frame_start, 1);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_words_sent", words_sent, 0);
        check("rst_underflow", underflow, 0);
        #2 rst_n = 1'b1;

        // Word pushed at slot 3 goes out in frame 1.
        wait_slot(3);
        push(32'hA5A5_0F0F);
        wait_slot(0);
        check("t1_first_bit", dout, 1);
        check("t1_active", frame_active, 1);
        check("t1_words_sent", words_sent, 1);
        wait_slot(4);
        check("t1_bit4", dout, 0);
        wait_slot(WIDTH);
        @(negedge clk);
        check("t1_rx_count", rx.size(), 1);
        check("t1_rx_word", rx[0], 32'hA5A5_0F0F);

        // Nothing queued: frame 2 is idle with an underflow pulse at slot 0.
        check("t3_underflow", underflow, 1);
        check("t3_idle", frame_active, 0);
        check("t3_words_sent", words_sent, 1);
        @(negedge clk);
        check("t3_underflow_1cyc", underflow, 0);
        wait_slot(10);
        check("t3_dout_idle", dout, 0);

        // Push on the gap edge with an empty FIFO: no bypass into the frame that follows.
        wait_slot(WIDTH);
        push(32'h1234_5678);
        check("t4_underflow", underflow, 1);
        check("t4_idle", frame_active, 0);
        check("t4_level", fifo_level, 1);
        wait_slot(0);
        check("t4_active_next", frame_active, 1);
        check("t4_level_next", fifo_level, 0);
        check("t4_words_sent", words_sent, 2);

        // Six back-to-back pushes from reset.
        do_reset();
        words6 = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                   32'h0F0F_F0F0, 32'h5555_AAAA};
        for (int i = 0; i < 6; i++) begin
            push(words6[i]);
            if (i == 3) begin
                check("t2_ready_full", tx_ready, 0);
                check("t2_level_full", fifo_level, 4);
            end
        end
        drain();
        check("t2_rx_count", rx.size(), 6);
        bad = 0;
        for (int i = 0; i < 6 && i < rx.size(); i++) if (rx[i] !== words6[i]) bad++;
        check("t2_rx_order", bad, 0);
        check("t2_max_level", max_lvl, 4);
        check("t2_words_sent", words_sent, 6);

        // Reset mid-frame with three words still queued.
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h1111_1111 * (i + 1));
        wait_slot(0);
        wait_slot(17);
        check("t5_level_before", fifo_level, 3);
        check("t5_active_before", frame_active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_dout", dout, 0);
        check("t5_level", fifo_level, 0);
        check("t5_ready", tx_ready, 1);
        check("t5_words_sent", words_sent, 0);
        check("t5_frame_start", frame_start, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_slot(5);
        check("t5_post_idle", frame_active, 0);
        wait_slot(0);
        check("t5_post_underflow", underflow, 1);

        // 100 random words with random idle gaps.
        do_reset();
        sent.delete();
        for (int i = 0; i < 100; i++) begin
            logic [WIDTH-1:0] w;
            repeat ($urandom_range(0, 50)) @(negedge clk);
            w = $urandom;
            sent.push_back(w);
            push(w);
        end
        drain();
        check("t6_words_sent", words_sent, 100);
        check("t6_rx_count", rx.size(), 100);
        bad = 0;
        for (int i = 0; i < 100 && i < rx.size(); i++) if (rx[i] !== sent[i]) bad++;
        check("t6_rx_order", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
